// File: rtl/sprite_pkg.sv
// Shared sprite constants for the player-1 action sequencer.
// Holds frame codes, FSM state enum, controller bit map and frame/phase helpers.
package sprite_pkg;

  localparam int unsigned FRAME_W = 4;
  localparam int unsigned INPUT_W = 7;
  localparam int unsigned PHASE_W = 2;

  localparam logic [FRAME_W-1:0] FRAME_STAND      = 4'd0;
  localparam logic [FRAME_W-1:0] FRAME_WALK1      = 4'd1;
  localparam logic [FRAME_W-1:0] FRAME_WALK2      = 4'd2;
  localparam logic [FRAME_W-1:0] FRAME_PUNCH_WIND = 4'd3;
  localparam logic [FRAME_W-1:0] FRAME_PUNCH_HIT  = 4'd4;
  localparam logic [FRAME_W-1:0] FRAME_KICK_WIND  = 4'd5;
  localparam logic [FRAME_W-1:0] FRAME_KICK_HIT   = 4'd6;
  localparam logic [FRAME_W-1:0] FRAME_BLOCK      = 4'd7;
  localparam logic [FRAME_W-1:0] FRAME_HIT        = 4'd8;

  localparam int unsigned IN_JUMP  = 0;
  localparam int unsigned IN_LEFT  = 1;
  localparam int unsigned IN_RIGHT = 2;
  localparam int unsigned IN_PUNCH = 3;
  localparam int unsigned IN_KICK  = 4;
  localparam int unsigned IN_BLOCK = 5;
  localparam int unsigned IN_RSVD  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WALK,
    ST_BLOCK,
    ST_PUNCH,
    ST_KICK,
    ST_HIT
  } p1_state_e;

  function automatic logic is_busy(input p1_state_e st);
    logic b;
    b = (st == ST_PUNCH) || (st == ST_KICK) || (st == ST_HIT);
    return b;
  endfunction

  // Phase index of the final tick in each timed state.
  function automatic logic [PHASE_W-1:0] last_phase(input p1_state_e st,
                                                   input logic [PHASE_W-1:0] stun_last);
    logic [PHASE_W-1:0] p;
    p = '0;
    case (st)
      ST_PUNCH: p = PHASE_W'(1);
      ST_KICK:  p = PHASE_W'(2);
      ST_HIT:   p = stun_last;
      default:  p = '0;
    endcase
    return p;
  endfunction

  function automatic logic [FRAME_W-1:0] frame_for(input p1_state_e st,
                                                  input logic [PHASE_W-1:0] phase);
    logic [FRAME_W-1:0] f;
    f = FRAME_STAND;
    case (st)
      ST_WALK:  f = phase[0] ? FRAME_WALK2 : FRAME_WALK1;
      ST_BLOCK: f = FRAME_BLOCK;
      ST_PUNCH: f = (phase == '0) ? FRAME_PUNCH_WIND : FRAME_PUNCH_HIT;
      ST_KICK:  f = (phase == '0) ? FRAME_KICK_WIND : FRAME_KICK_HIT;
      ST_HIT:   f = FRAME_HIT;
      default:  f = FRAME_STAND;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/anim_tick_gen.sv
// Animation tick divider: counts TICK_DIV clk cycles, tick is high while the count sits at TICK_DIV-1.
// tick_next_c flags that the following cycle will carry a tick.
module anim_tick_gen #(
  parameter int unsigned TICK_DIV = 15_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic tick_next_c
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);

  logic [CNT_W-1:0] cnt_q;

  assign tick_next_c = !clr && (cnt_q == CNT_PRE);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= tick_next_c;
    end
  end

endmodule

// File: rtl/p1_action_sequencer.sv
// Player-1 action FSM: controller inputs and hit strobe to sprite frame, walk steps and attack flag.
// Define P1_ATTACK_BUFFER_EN to queue one punch/kick edge arriving during an attack.
module p1_action_sequencer
  import sprite_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 15_000_000,
  parameter int unsigned STUN_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INPUT_W-1:0] player1_inputs,
  input  logic               hit_in,
  output logic [FRAME_W-1:0] frame_sel,
  output logic               step_left,
  output logic               step_right,
  output logic               attack_active,
  output logic               busy
);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 2");
  end
  if (STUN_TICKS < 1 || STUN_TICKS > 4) begin : g_bad_stun_ticks
    $error("STUN_TICKS must be in 1..4");
  end

  localparam logic [PHASE_W-1:0] STUN_LAST = PHASE_W'(STUN_TICKS - 1);

  p1_state_e          state_q, state_nxt;
  logic [PHASE_W-1:0] phase_q, phase_nxt;
  logic               prev_punch_q, prev_kick_q;
  logic               tick, tick_next_c, clr;
  logic               punch_edge, kick_edge, left, right, block, walk;
  logic               final_tick, busy_hold;
  logic [FRAME_W-1:0] frame_nxt;
  logic               attack_nxt, busy_nxt, step_left_nxt, step_right_nxt;
  logic               unused_inputs;

`ifdef P1_ATTACK_BUFFER_EN
  logic buf_valid_q, buf_valid_nxt;
  logic buf_kick_q, buf_kick_nxt;
`endif

  assign unused_inputs = player1_inputs[IN_JUMP] ^ player1_inputs[IN_RSVD];

  anim_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .tick        (tick),
    .tick_next_c (tick_next_c)
  );

  // Input decode and end-of-attack detection.
  always_comb begin
    punch_edge = player1_inputs[IN_PUNCH] && !prev_punch_q;
    kick_edge  = player1_inputs[IN_KICK] && !prev_kick_q;
    left       = player1_inputs[IN_LEFT];
    right      = player1_inputs[IN_RIGHT];
    block      = player1_inputs[IN_BLOCK];
    walk       = left ^ right;
    final_tick = tick && (phase_q == last_phase(state_q, STUN_LAST));
    busy_hold  = is_busy(state_q) && !final_tick;
  end

  // Next state in priority order: hit, running attack, punch, kick, (buffer), block, walk, idle.
  always_comb begin
    state_nxt = ST_IDLE;
    phase_nxt = '0;
    clr       = 1'b0;
`ifdef P1_ATTACK_BUFFER_EN
    buf_valid_nxt = buf_valid_q;
    buf_kick_nxt  = buf_kick_q;
`endif
    if (hit_in) begin
      state_nxt = ST_HIT;
      clr       = 1'b1;
`ifdef P1_ATTACK_BUFFER_EN
      buf_valid_nxt = 1'b0;
`endif
    end else if (busy_hold) begin
      state_nxt = state_q;
      phase_nxt = tick ? phase_q + PHASE_W'(1) : phase_q;
`ifdef P1_ATTACK_BUFFER_EN
      if (state_q != ST_HIT && (punch_edge || kick_edge)) begin
        buf_valid_nxt = 1'b1;
        buf_kick_nxt  = !punch_edge;
      end
`endif
    end else begin
      if (punch_edge) state_nxt = ST_PUNCH;
      else if (kick_edge) state_nxt = ST_KICK;
`ifdef P1_ATTACK_BUFFER_EN
      else if (buf_valid_q) state_nxt = buf_kick_q ? ST_KICK : ST_PUNCH;
`endif
      else if (block) state_nxt = ST_BLOCK;
      else if (walk) state_nxt = ST_WALK;
      else state_nxt = ST_IDLE;
`ifdef P1_ATTACK_BUFFER_EN
      buf_valid_nxt = 1'b0;
`endif
      // A freshly started attack restarts its timing even from the same state.
      if (state_nxt != state_q || state_nxt == ST_PUNCH || state_nxt == ST_KICK) begin
        clr = 1'b1;
      end else if (state_nxt == ST_WALK) begin
        phase_nxt = tick ? {1'b0, ~phase_q[0]} : phase_q;
      end
    end
    frame_nxt  = frame_for(state_nxt, phase_nxt);
    attack_nxt = ((state_nxt == ST_PUNCH) && (phase_nxt == PHASE_W'(1))) ||
                 ((state_nxt == ST_KICK) && (phase_nxt != '0));
    busy_nxt   = is_busy(state_nxt);
  end

  // Steps line up with the cycle in which the walk tick is high.
  always_comb begin
    step_left_nxt  = (state_nxt == ST_WALK) && tick_next_c && left;
    step_right_nxt = (state_nxt == ST_WALK) && tick_next_c && right;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      prev_punch_q  <= 1'b0;
      prev_kick_q   <= 1'b0;
      frame_sel     <= FRAME_STAND;
      step_left     <= 1'b0;
      step_right    <= 1'b0;
      attack_active <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      phase_q       <= phase_nxt;
      prev_punch_q  <= player1_inputs[IN_PUNCH];
      prev_kick_q   <= player1_inputs[IN_KICK];
      frame_sel     <= frame_nxt;
      step_left     <= step_left_nxt;
      step_right    <= step_right_nxt;
      attack_active <= attack_nxt;
      busy          <= busy_nxt;
    end
  end

`ifdef P1_ATTACK_BUFFER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_kick_q  <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_nxt;
      buf_kick_q  <= buf_kick_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_p1_action_sequencer.sv
// Directed bench for p1_action_sequencer with a cycle-elapsed behavioural model checked every cycle.
module tb_p1_action_sequencer;

  localparam int TD = 4;
  localparam int STN = 2;
  localparam int M_IDLE = 0, M_WALK = 1, M_BLOCK = 2, M_PUNCH = 3, M_KICK = 4, M_HIT = 5;
  localparam logic [6:0] B_L = 7'h02, B_R = 7'h04, B_P = 7'h08, B_K = 7'h10, B_B = 7'h20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] player1_inputs = '0;
  logic       hit_in = 1'b0;
  logic [3:0] frame_sel;
  logic       step_left, step_right, attack_active, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  p1_action_sequencer #(
    .TICK_DIV   (TD),
    .STUN_TICKS (STN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .player1_inputs (player1_inputs),
    .hit_in         (hit_in),
    .frame_sel      (frame_sel),
    .step_left      (step_left),
    .step_right     (step_right),
    .attack_active  (attack_active),
    .busy           (busy)
  );

  // Model state: current action and cycles elapsed since entering it.
  int m_mode = M_IDLE;
  int m_el = 0;
  int m_buf = M_IDLE;
  int m_nm;
  bit m_buf_v = 0, m_prev_p = 0, m_prev_k = 0, m_sl = 0, m_sr = 0, m_valid = 0;
  bit m_p, m_k, m_pe, m_ke, m_l, m_r, m_b;

  function automatic int dur(input int m);
    case (m)
      M_PUNCH: return 2 * TD;
      M_KICK:  return 3 * TD;
      M_HIT:   return STN * TD;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_frame();
    case (m_mode)
      M_WALK:  return ((m_el / TD) % 2 == 1) ? 2 : 1;
      M_BLOCK: return 7;
      M_PUNCH: return (m_el < TD) ? 3 : 4;
      M_KICK:  return (m_el < TD) ? 5 : 6;
      M_HIT:   return 8;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    m_p  = player1_inputs[3];
    m_k  = player1_inputs[4];
    m_l  = player1_inputs[1];
    m_r  = player1_inputs[2];
    m_b  = player1_inputs[5];
    m_pe = m_p && !m_prev_p;
    m_ke = m_k && !m_prev_k;
    if (rst) begin
      m_mode = M_IDLE; m_el = 0; m_buf_v = 0;
      m_prev_p = 0; m_prev_k = 0; m_sl = 0; m_sr = 0;
    end else begin
      if (hit_in) begin
        m_mode = M_HIT; m_el = 0; m_buf_v = 0;
      end else if (m_mode >= M_PUNCH && m_el + 1 < dur(m_mode)) begin
        m_el = m_el + 1;
`ifdef P1_ATTACK_BUFFER_EN
        if (m_mode != M_HIT) begin
          if (m_pe) begin m_buf = M_PUNCH; m_buf_v = 1; end
          else if (m_ke) begin m_buf = M_KICK; m_buf_v = 1; end
        end
`endif
      end else begin
        if (m_pe) m_nm = M_PUNCH;
        else if (m_ke) m_nm = M_KICK;
        else if (m_buf_v) m_nm = m_buf;
        else if (m_b) m_nm = M_BLOCK;
        else if (m_l != m_r) m_nm = M_WALK;
        else m_nm = M_IDLE;
        if (m_nm != m_mode || m_nm == M_PUNCH || m_nm == M_KICK) m_el = 0;
        else m_el = m_el + 1;
        m_mode = m_nm;
        m_buf_v = 0;
      end
      m_sl = (m_mode == M_WALK) && m_l && (m_el % TD == TD - 1);
      m_sr = (m_mode == M_WALK) && m_r && (m_el % TD == TD - 1);
      m_prev_p = m_p;
      m_prev_k = m_k;
    end
    m_valid = 1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if (int'(frame_sel) != exp_frame() || step_left !== m_sl || step_right !== m_sr ||
          attack_active !== (m_mode >= M_PUNCH && m_mode <= M_KICK && m_el >= TD) ||
          busy !== (m_mode >= M_PUNCH)) begin
        fails++;
        $display("FAIL model t=%0t: got frame %0d sl %0b sr %0b atk %0b busy %0b, want frame %0d sl %0b sr %0b atk %0b busy %0b",
                 $time, frame_sel, step_left, step_right, attack_active, busy, exp_frame(), m_sl, m_sr,
                 (m_mode >= M_PUNCH && m_mode <= M_KICK && m_el >= TD), (m_mode >= M_PUNCH));
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [6:0] in, input logic hit, input logic r);
    player1_inputs = in;
    hit_in = hit;
    rst = r;
    @(negedge clk);
  endtask

  int n, first;

  initial begin
    repeat (3) cyc('0, 1'b0, 1'b1);
    chk("reset_frame", int'(frame_sel), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_attack", int'(attack_active), 0);
    repeat (2) cyc('0, 1'b0, 1'b0);

    n = 0; first = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc(B_R, 1'b0, 1'b0);
      if (i == 1) chk("walk_first_frame", int'(frame_sel), 1);
      if (i == 5) chk("walk_toggle_frame", int'(frame_sel), 2);
      if (step_right) begin n++; if (first == 0) first = i; end
    end
    chk("walk_step_count", n, 4);
    chk("walk_first_step", first, 4);

    n = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(B_L | B_R, 1'b0, 1'b0);
      if (step_left || step_right) n++;
    end
    chk("walk_both_frame", int'(frame_sel), 0);
    chk("walk_both_steps", n, 0);
    repeat (6) cyc(B_L, 1'b0, 1'b0);
    repeat (2) cyc('0, 1'b0, 1'b0);

    repeat (4) cyc(B_B, 1'b0, 1'b0);
    chk("block_frame", int'(frame_sel), 7);
    repeat (5) cyc(B_B | B_R, 1'b0, 1'b0);
    chk("block_walk_frame", int'(frame_sel), 7);
    repeat (2) cyc('0, 1'b0, 1'b0);

    for (int i = 1; i <= 10; i++) begin
      cyc((i == 1) ? B_P : 7'h00, 1'b0, 1'b0);
      if (i == 1) chk("punch_wind_start", int'(frame_sel), 3);
      if (i == 4) chk("punch_wind_end", int'(frame_sel), 3);
      if (i == 5) begin
        chk("punch_hit_frame", int'(frame_sel), 4);
        chk("punch_hit_attack", int'(attack_active), 1);
      end
      if (i == 9) begin
        chk("punch_done_frame", int'(frame_sel), 0);
        chk("punch_done_attack", int'(attack_active), 0);
      end
    end
    for (int i = 1; i <= 12; i++) cyc(B_P, 1'b0, 1'b0);
    chk("punch_held_no_repeat", int'(frame_sel), 0);
    repeat (2) cyc('0, 1'b0, 1'b0);

    for (int i = 1; i <= 16; i++) begin
      cyc((i == 1) ? B_K : 7'h00, i == 7, 1'b0);
      if (i == 5) chk("kick_hit_attack", int'(attack_active), 1);
      if (i == 7) begin
        chk("hit_frame", int'(frame_sel), 8);
        chk("hit_attack_low", int'(attack_active), 0);
      end
      if (i == 14) chk("hit_last_frame", int'(frame_sel), 8);
      if (i == 15) chk("hit_recover", int'(frame_sel), 0);
    end

    for (int i = 1; i <= 15; i++) begin
      cyc('0, (i == 1) || (i == 6), 1'b0);
      if (i == 13) chk("restun_frame", int'(frame_sel), 8);
      if (i == 14) chk("restun_recover", int'(frame_sel), 0);
    end

    cyc(B_P, 1'b1, 1'b0);
    chk("hit_beats_punch", int'(frame_sel), 8);
    for (int i = 2; i <= 10; i++) cyc(B_P, 1'b0, 1'b0);
    chk("punch_edge_discarded", int'(frame_sel), 0);
    repeat (2) cyc('0, 1'b0, 1'b0);

    for (int i = 1; i <= 22; i++) begin
      cyc((i == 1) ? B_P : ((i == 2) ? B_K : 7'h00), 1'b0, 1'b0);
      if (i == 8) chk("buf_punch_hit", int'(frame_sel), 4);
`ifdef P1_ATTACK_BUFFER_EN
      if (i == 9) chk("buf_kick_follows", int'(frame_sel), 5);
`else
      if (i == 9) chk("nobuf_idle_follows", int'(frame_sel), 0);
`endif
    end

    for (int i = 1; i <= 5; i++) cyc((i == 1) ? B_K : 7'h00, 1'b0, 1'b0);
    chk("pre_reset_kick_hit", int'(frame_sel), 6);
    cyc(B_P, 1'b0, 1'b1);
    chk("rst_frame", int'(frame_sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_attack", int'(attack_active), 0);
    cyc(B_P, 1'b0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      cyc(B_P, 1'b0, 1'b0);
      if (i == 1) chk("held_punch_fires", int'(frame_sel), 3);
      if (i == 12) chk("held_punch_once", int'(frame_sel), 0);
    end
    repeat (3) cyc('0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/p1_action_sequencer.md
# p1_action_sequencer

Player-1 action state machine that turns the 7-bit controller inputs and a hit strobe into a 4-bit sprite frame select, walk step strobes and an attack-active flag. It sits between the input decoder and the player sprite pixel mux and the position logic. It owns all animation timing, so the sprite mux becomes a plain frame-indexed select. Attacks are edge-triggered and non-interruptible except by a hit.

## Interface
- `TICK_DIV`, 15_000_000: clk cycles per animation tick (≥2).
- `STUN_TICKS`, 4: ticks spent in hit-stun.
- `clk` in 1: system clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `player1_inputs` in 7: bit 0 jump (unused here), 1 left, 2 right, 3 punch, 4 kick, 5 block, 6 reserved.
- `hit_in` in 1: one-cycle strobe from collision logic; player was struck.
- `frame_sel` out 4: 0 STAND, 1 WALK1, 2 WALK2, 3 PUNCH_WIND, 4 PUNCH_HIT, 5 KICK_WIND, 6 KICK_HIT, 7 BLOCK, 8 HIT.
- `step_left` / `step_right` out 1: one-cycle pulse per tick while walking.
- `attack_active` out 1: high during PUNCH_HIT / KICK_HIT frames.
- `busy` out 1: high in PUNCH, KICK, HIT.

## Operation
- States: IDLE, WALK, BLOCK, PUNCH, KICK, HIT. The tick counter clears on every state change and on reset. A tick fires when the counter reaches TICK_DIV-1; the counter then wraps to 0.
- Punch and kick are rising-edge detected: bit high this cycle and low in the previous-sample register. The previous-sample register resets to 0, so a button held through reset fires once.
- Priority evaluated every cycle: hit_in > busy attack continues > punch edge > kick edge > block held > walk > IDLE.
- Walk: exactly one of left/right high. Both high or neither high means no walk.
- IDLE: frame 0.
- WALK: frame starts at 1 and toggles 1↔2 on each tick. step_left or step_right pulses on the same tick.
- BLOCK: frame 7 while bit 5 is held. No steps are issued.
- PUNCH: frame 3 for 1 tick, then frame 4 for 1 tick with attack_active high. On the final tick, priority is re-evaluated without the busy term.
- KICK: frame 5 for 1 tick, then frame 6 for 2 ticks with attack_active high.
- HIT: entered from any state, including HIT itself, which restarts the stun. Frame 8 for STUN_TICKS ticks. attack_active is low throughout. Then priority is re-evaluated.
- Attack edges that arrive while busy are handled per the Configuration section.
- Width rule: the tick counter is $clog2(TICK_DIV) bits. The sub-tick phase counter is 2 bits and saturates at STUN_TICKS-1, with STUN_TICKS ≤ 4 enforced by an elaboration check.

## Timing
- All outputs are registered. Reset values: frame_sel=0, step_left=0, step_right=0, attack_active=0, busy=0, state IDLE, counters 0.
- Input sampled at edge N produces the new frame_sel at edge N: 1-cycle latency from the input changing.
- PUNCH lasts exactly 2·TICK_DIV cycles. KICK lasts 3·TICK_DIV cycles. HIT lasts STUN_TICKS·TICK_DIV cycles.
- Step pulses are exactly 1 cycle wide, at the cycle the tick fires.
- hit_in in the same cycle as an attack edge: HIT wins and the edge is discarded.
- Reset mid-attack returns to IDLE at the next edge with attack_active=0.

## Configuration
- `P1_ATTACK_BUFFER_EN` defined: adds a one-entry attack buffer.
  - A punch or kick edge while in PUNCH/KICK is stored. The latest edge overwrites; punch wins a same-cycle tie.
  - On attack completion, the FSM enters the buffered attack directly, overriding block and walk.
  - hit_in or rst clears the buffer.
- Undefined: edges during PUNCH/KICK are dropped.

## Structure
- A shared package `sprite_pkg` holds the frame_sel constants (FRAME_STAND through FRAME_HIT), the state enum, and the input bit index constants (IN_LEFT, IN_RIGHT, IN_PUNCH, IN_KICK, IN_BLOCK).
- Sub-module `anim_tick_gen`: a TICK_DIV counter with synchronous clear input and a one-cycle tick output.

## Test plan
(All scenarios use TICK_DIV=4 and STUN_TICKS=2.)
- Hold right (bit 2) for 16 cycles: frame_sel is 1 then alternates 1/2 every 4 cycles, with four step_right pulses spaced 4 cycles apart. Holding left+right together gives frame 0 and no steps.
- Punch pulse at cycle 10: frames 3 for cycles 10–13 and 4 for cycles 14–17 with attack_active high, then frame 0 at cycle 18. Holding punch produces no repeat.
- Kick edge, then hit_in at the second cycle of frame 6: frame 8 immediately with attack_active=0, stays 8 for 8 cycles, then returns to frame 0.
- hit_in asserted again at cycle 5 of stun: the stun restarts and frame 8 persists 8 more cycles.
- With P1_ATTACK_BUFFER_EN, kick edge during punch wind-up: the punch completes and frame 5 follows with no IDLE gap. Without the macro: frame 0 follows.
- rst asserted during KICK_HIT: next cycle shows frame_sel=0, busy=0, attack_active=0. Punch held through reset fires once after rst drops.
